// File: rtl/e603_subsys_irq_gateway_pkg.sv
// Shared types and constants for the subsystem IRQ gateway.
// Gateway state encodings and the "no interrupt" claim ID.
package e603_subsys_irq_gateway_pkg;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_SERV = 2'd2
  } gw_state_e;

  localparam int ID_NONE = 0;

  // Edge sources trigger on a synchronized rising edge, level sources on a high level.
  function automatic logic gw_trigger(input logic edge_mode, input logic s, input logic rise);
    return edge_mode ? rise : s;
  endfunction

endpackage

// File: rtl/e603_subsys_irq_gateway_if.sv
// Core-side interrupt request and claim/complete handshake.
// The core drives the strobes (master); the gateway answers (slave).
interface e603_subsys_irq_gateway_if #(
  parameter int ID_W = 6
) ();

  logic            claim_req;
  logic            claim_ack;
  logic [ID_W-1:0] claim_id;
  logic            cmpl_vld;
  logic [ID_W-1:0] cmpl_id;
  logic            irq_req;

  modport master (
    output claim_req, cmpl_vld, cmpl_id,
    input  claim_ack, claim_id, irq_req
  );

  modport slave (
    input  claim_req, cmpl_vld, cmpl_id,
    output claim_ack, claim_id, irq_req
  );

endinterface

// File: rtl/e603_subsys_irq_gate_cell.sv
// Per-source gateway: synchronizer, edge detect, IDLE/PEND/SERV state and
// a one-deep held edge that re-pends the source on completion.
module e603_subsys_irq_gate_cell
  import e603_subsys_irq_gateway_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  input  logic edge_mode,
  input  logic claim_win,
  input  logic cmpl_hit,
  output logic pend
);

  logic      s;
  logic      s_prev_q;
  logic      rise;
  logic      held_q, held_d;
  gw_state_e state_q, state_d;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = irq_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q, sync_d;

      always_comb begin
        sync_d[0] = irq_in;
        for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
      end

      always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise = s & ~s_prev_q;

  // A completion racing a fresh edge re-pends rather than losing the edge.
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    case (state_q)
      GW_IDLE: if (gw_trigger(edge_mode, s, rise)) state_d = GW_PEND;
      GW_PEND: if (claim_win) state_d = GW_SERV;
      GW_SERV: begin
        if (cmpl_hit) begin
          state_d = (held_q || (edge_mode && rise)) ? GW_PEND : GW_IDLE;
          held_d  = 1'b0;
        end else if (edge_mode && rise) begin
          held_d = 1'b1;
        end
      end
      default: begin
        state_d = GW_IDLE;
        held_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GW_IDLE;
      held_q   <= 1'b0;
      s_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      held_q   <= held_d;
      s_prev_q <= s;
    end
  end

  assign pend = (state_q == GW_PEND);

endmodule

// File: rtl/e603_subsys_irq_gateway.sv
// Receive-side IRQ gateway: per-source gate cells, lowest-index priority
// selection and registered claim/complete handshake toward the core.
module e603_subsys_irq_gateway
  import e603_subsys_irq_gateway_pkg::*;
#(
  parameter int IRQ_NUM     = 51,
  parameter int ID_W        = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_NUM-1:0] irq_in,
  input  logic [IRQ_NUM-1:0] irq_en,
  input  logic [IRQ_NUM-1:0] irq_edge,
  output logic [IRQ_NUM-1:0] irq_pend,
  e603_subsys_irq_gateway_if.slave core
);

  logic [IRQ_NUM-1:0] eligible;
  logic [IRQ_NUM-1:0] claim_win;
  logic [IRQ_NUM-1:0] cmpl_hit;
  logic [ID_W-1:0]    winner_id;
  logic               winner_vld;

  logic               claim_ack_q, claim_ack_d;
  logic [ID_W-1:0]    claim_id_q, claim_id_d;
  logic               irq_req_q, irq_req_d;

  for (genvar g = 0; g < IRQ_NUM; g++) begin : g_cell
    e603_subsys_irq_gate_cell #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .irq_in   (irq_in[g]),
      .edge_mode(irq_edge[g]),
      .claim_win(claim_win[g]),
      .cmpl_hit (cmpl_hit[g]),
      .pend     (irq_pend[g])
    );
  end

  assign eligible = irq_pend & irq_en;

  // Scan from the top so the lowest eligible index is the last one kept.
  always_comb begin
    winner_vld = 1'b0;
    winner_id  = ID_W'(ID_NONE);
    claim_win  = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner_vld   = 1'b1;
        winner_id    = ID_W'(i + 1);
        claim_win    = '0;
        claim_win[i] = core.claim_req;
      end
    end
  end

  always_comb begin
    cmpl_hit = '0;
    for (int i = 0; i < IRQ_NUM; i++)
      cmpl_hit[i] = core.cmpl_vld && (core.cmpl_id == ID_W'(i + 1));
  end

  always_comb begin
    claim_ack_d = core.claim_req;
    claim_id_d  = claim_id_q;
    irq_req_d   = |eligible;
    if (core.claim_req) claim_id_d = winner_vld ? winner_id : ID_W'(ID_NONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      claim_ack_q <= 1'b0;
      claim_id_q  <= '0;
      irq_req_q   <= 1'b0;
    end else begin
      claim_ack_q <= claim_ack_d;
      claim_id_q  <= claim_id_d;
      irq_req_q   <= irq_req_d;
    end
  end

  assign core.claim_ack = claim_ack_q;
  assign core.claim_id  = claim_id_q;
  assign core.irq_req   = irq_req_q;

endmodule

// File: tb/tb_e603_subsys_irq_gateway.sv
// Self-checking bench for e603_subsys_irq_gateway: directed scenarios plus
// randomized traffic, all compared against a vector-level behavioural model.
module tb_e603_subsys_irq_gateway;

  localparam int N    = 51;
  localparam int ID_W = 6;
  localparam int S    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in, irq_en, irq_edge, irq_pend;

  e603_subsys_irq_gateway_if #(.ID_W(ID_W)) bus ();

  e603_subsys_irq_gateway #(
    .IRQ_NUM    (N),
    .ID_W       (ID_W),
    .SYNC_STAGES(S)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_in  (irq_in),
    .irq_en  (irq_en),
    .irq_edge(irq_edge),
    .irq_pend(irq_pend),
    .core    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus values applied on the next call to applyStimulus.
  logic            rst_v;
  logic [N-1:0]    in_v;
  logic            cr_v, cv_v;
  logic [ID_W-1:0] cid_v;

  // Reference model: pending/in-service/held as plain bit vectors.
  logic [N-1:0]    pend_m, serv_m, held_m;
  logic            ack_m, req_m;
  logic [ID_W-1:0] id_m;
  logic [N-1:0]    hist[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep();
    logic [N-1:0] s, sp, rise, trig, elig, win, hit;
    int cid;
    if (rst) begin
      pend_m = '0; serv_m = '0; held_m = '0;
      ack_m = 1'b0; req_m = 1'b0; id_m = '0;
      hist.delete();
      for (int k = 0; k <= S; k++) hist.push_back('0);
      return;
    end
    hist.push_back(irq_in);
    if (hist.size() > S + 2) void'(hist.pop_front());
    s    = hist[hist.size() - 1 - S];
    sp   = hist[hist.size() - 2 - S];
    rise = s & ~sp;
    trig = (irq_edge & rise) | (~irq_edge & s);
    elig = pend_m & irq_en;
    req_m = |elig;
    ack_m = bus.claim_req;
    win = '0;
    if (bus.claim_req) begin
      id_m = '0;
      for (int i = 0; i < N; i++)
        if (elig[i]) begin win[i] = 1'b1; id_m = ID_W'(i + 1); break; end
    end
    hit = '0;
    cid = int'(bus.cmpl_id);
    if (bus.cmpl_vld && cid >= 1 && cid <= N) hit[cid-1] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (serv_m[i]) begin
        if (hit[i]) begin
          serv_m[i] = 1'b0;
          pend_m[i] = held_m[i] | (irq_edge[i] & rise[i]);
          held_m[i] = 1'b0;
        end else if (irq_edge[i] & rise[i]) begin
          held_m[i] = 1'b1;
        end
      end else if (pend_m[i]) begin
        if (win[i]) begin pend_m[i] = 1'b0; serv_m[i] = 1'b1; end
      end else if (trig[i]) begin
        pend_m[i] = 1'b1;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("pend", 64'(irq_pend), 64'(pend_m));
    checkOutput("req", 64'(bus.irq_req), 64'(req_m));
    checkOutput("ack", 64'(bus.claim_ack), 64'(ack_m));
    if (ack_m) checkOutput("id", 64'(bus.claim_id), 64'(id_m));
  endtask

  task automatic applyStimulus();
    rst           = rst_v;
    irq_in        = in_v;
    bus.claim_req = cr_v;
    bus.cmpl_vld  = cv_v;
    bus.cmpl_id   = cid_v;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll();
    cr_v = 1'b0; cv_v = 1'b0; cid_v = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) applyStimulus();
  endtask

  task automatic doClaim();
    cr_v = 1'b1;
    applyStimulus();
  endtask

  task automatic doCmpl(input int id);
    cv_v = 1'b1; cid_v = ID_W'(id);
    applyStimulus();
  endtask

  task automatic pulse(input int src);
    in_v[src] = 1'b1; applyStimulus();
    in_v[src] = 1'b0; tick(3);
  endtask

  initial begin
    rst_v = 1'b1; in_v = '0; cr_v = 1'b0; cv_v = 1'b0; cid_v = '0;
    irq_en = '1; irq_edge = '0; irq_edge[7] = 1'b1; irq_edge[4] = 1'b1;
    tick(3);
    checkOutput("rst_pend", 64'(irq_pend), 64'd0);
    checkOutput("rst_req", 64'(bus.irq_req), 64'd0);
    checkOutput("rst_ack", 64'(bus.claim_ack), 64'd0);
    rst_v = 1'b0;

    // Level source 5 latency, claim and re-pend with line still high.
    in_v[5] = 1'b1;
    tick(2); checkOutput("l5_pend_early", 64'(irq_pend[5]), 64'd0);
    tick(1); checkOutput("l5_pend", 64'(irq_pend[5]), 64'd1);
             checkOutput("l5_req_early", 64'(bus.irq_req), 64'd0);
    tick(1); checkOutput("l5_req", 64'(bus.irq_req), 64'd1);
    doClaim();
    checkOutput("l5_ack", 64'(bus.claim_ack), 64'd1);
    checkOutput("l5_id", 64'(bus.claim_id), 64'd6);
    checkOutput("l5_serv", 64'(irq_pend[5]), 64'd0);
    doCmpl(6); checkOutput("l5_idle", 64'(irq_pend[5]), 64'd0);
    tick(1);   checkOutput("l5_repend", 64'(irq_pend[5]), 64'd1);
    in_v[5] = 1'b0;
    doClaim(); checkOutput("l5_id2", 64'(bus.claim_id), 64'd6);
    doCmpl(6); tick(3);
    checkOutput("l5_done", 64'(irq_pend[5]), 64'd0);

    // Sources 3 and 40 together, back-to-back claims.
    in_v[3] = 1'b1; in_v[40] = 1'b1;
    tick(4);
    in_v[3] = 1'b0; in_v[40] = 1'b0;
    doClaim(); checkOutput("p_id4", 64'(bus.claim_id), 64'd4);
    doClaim(); checkOutput("p_id41", 64'(bus.claim_id), 64'd41);
               checkOutput("p_req_hold", 64'(bus.irq_req), 64'd1);
    doClaim(); checkOutput("p_id0", 64'(bus.claim_id), 64'd0);
               checkOutput("p_req_fall", 64'(bus.irq_req), 64'd0);
    doCmpl(4); doCmpl(41); tick(2);

    // Edge source 7 with a held edge, and an uncounted edge while pending.
    pulse(7);  checkOutput("e7_pend", 64'(irq_pend[7]), 64'd1);
    doClaim(); checkOutput("e7_id", 64'(bus.claim_id), 64'd8);
    pulse(7);  checkOutput("e7_serv", 64'(irq_pend[7]), 64'd0);
    doCmpl(8); checkOutput("e7_held_repend", 64'(irq_pend[7]), 64'd1);
    tick(1);   checkOutput("e7_req", 64'(bus.irq_req), 64'd1);
    pulse(7);
    doClaim(); checkOutput("e7_id2", 64'(bus.claim_id), 64'd8);
    doCmpl(8); checkOutput("e7_no_count", 64'(irq_pend[7]), 64'd0);
    tick(2);

    // Disabled pending source 2, then enabled.
    irq_en[2] = 1'b0; in_v[2] = 1'b1;
    tick(4);
    checkOutput("d2_pend", 64'(irq_pend[2]), 64'd1);
    checkOutput("d2_req", 64'(bus.irq_req), 64'd0);
    doClaim(); checkOutput("d2_id0", 64'(bus.claim_id), 64'd0);
    irq_en[2] = 1'b1;
    tick(1);   checkOutput("d2_req_en", 64'(bus.irq_req), 64'd1);
    doClaim(); checkOutput("d2_id3", 64'(bus.claim_id), 64'd3);
    in_v[2] = 1'b0; tick(2); doCmpl(3); tick(1);
    checkOutput("d2_idle", 64'(irq_pend[2]), 64'd0);

    // Ignored completions and same-cycle claim plus completion.
    in_v[1] = 1'b1; in_v[9] = 1'b1;
    tick(4);
    in_v[1] = 1'b0; in_v[9] = 1'b0;
    doClaim(); checkOutput("c_id2", 64'(bus.claim_id), 64'd2);
    tick(2);
    doCmpl(0); doCmpl(60); doCmpl(10);
    checkOutput("c_p9", 64'(irq_pend[9]), 64'd1);
    cr_v = 1'b1; cv_v = 1'b1; cid_v = ID_W'(2);
    applyStimulus();
    checkOutput("c_id10", 64'(bus.claim_id), 64'd10);
    tick(1);   checkOutput("c_p1_idle", 64'(irq_pend[1]), 64'd0);
    doCmpl(10); tick(1);

    // Reset while source 4 is in service with a held edge and a claim pending.
    pulse(4);
    doClaim(); checkOutput("r4_id", 64'(bus.claim_id), 64'd5);
    pulse(4);
    rst_v = 1'b1; cr_v = 1'b1;
    applyStimulus();
    checkOutput("r_ack", 64'(bus.claim_ack), 64'd0);
    checkOutput("r_pend", 64'(irq_pend), 64'd0);
    checkOutput("r_req", 64'(bus.irq_req), 64'd0);
    rst_v = 1'b0;
    tick(5);   checkOutput("r4_stay_idle", 64'(irq_pend[4]), 64'd0);
    pulse(4);  checkOutput("r4_fresh", 64'(irq_pend[4]), 64'd1);
    doClaim(); doCmpl(5); tick(2);

    // Randomized traffic against the model.
    irq_edge = N'({$urandom, $urandom});
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) in_v[b] = ~in_v[b];
      if ($urandom_range(0, 49) == 0) irq_en[$urandom_range(0, N - 1)] ^= 1'b1;
      cr_v = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) begin
        int pick;
        pick = $urandom_range(0, N - 1);
        cv_v  = 1'b1;
        cid_v = serv_m[pick] ? ID_W'(pick + 1) : ID_W'($urandom_range(0, 63));
      end
      rst_v = ($urandom_range(0, 699) == 0);
      applyStimulus();
    end
    rst_v = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
